// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// ---------------------------------------------------------------------------
// Memory-to-memory copy / fill engine for the byte-per-word data memory.
// It sits next to the CPU on the data-memory port, behind a mux owned by the
// top level. The engine either copies a block of entries from a source area
// to a destination area, or fills a destination area with a constant byte.
// Completion is signalled by a one-cycle done pulse, together with an 8-bit
// running checksum of every byte written and a flag telling whether the
// transfer was cut short by abort.
//
// Ports
//   i_clk          sole clock, everything updates on its rising edge
//   i_rst          synchronous active-high reset
//   i_start        request a transfer (only looked at while idle)
//   i_mode         0 = copy src -> dst, 1 = fill dst with i_fill_value
//   i_abort        stop the active transfer early
//   i_src_addr     byte address of first source entry (word aligned inside)
//   i_dst_addr     byte address of first destination entry
//   i_len          number of entries, 0 .. 2**(LEN_W-1)
//   i_fill_value   fill byte
//   o_busy         high whenever the engine is not idle
//   o_done         one-cycle completion pulse
//   o_aborted      last transfer was aborted, valid from done until next start
//   o_checksum     mod-256 sum of the bytes written by the last transfer
//   o_mem_we       memory write enable
//   o_mem_addr     memory byte address (memory uses bits [31:2])
//   o_mem_wdata    memory write data
//   i_mem_rdata    memory read data, combinational from o_mem_addr
// ---------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int LEN_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_abort,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_fill_value,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [7:0]       o_checksum,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [7:0]       o_mem_wdata,
  input  logic [7:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Word-aligned address mask: the memory ignores the two low address bits,
  // so the pointers are kept aligned from the moment they are loaded.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t            r_state;
  state_t            w_next;

  logic [31:0]       r_srcPtr;
  logic [31:0]       r_dstPtr;
  logic [LEN_W-1:0]  r_count;
  logic [7:0]        r_dataQ;
  logic [7:0]        r_fillValue;
  logic              r_mode;
  logic [7:0]        r_checksum;
  logic              r_aborted;

  logic              w_memWe;
  logic [31:0]       w_memAddr;
  logic [7:0]        w_memWdata;
  logic              w_lastEntry;
  logic [31:0]       w_srcAligned;
  logic [31:0]       w_dstAligned;

  // Aligned start addresses. Masking (instead of slicing) keeps every input
  // bit formally in use while still forcing the low two bits to zero.
  assign w_srcAligned = i_src_addr & WORD_MASK;
  assign w_dstAligned = i_dst_addr & WORD_MASK;

  // The count holds the number of entries still to be written; the write
  // that sees a count of one is the final one of the block.
  assign w_lastEntry = (r_count == LEN_W'(1));

  // Next-state and Moore memory outputs. The memory-side outputs depend only
  // on the registered state and pointers, so the external mux and memory see
  // a clean, glitch-free address for the whole cycle. Abort only steers the
  // next state; a WRITE cycle that sees abort still completes its write.
  always_comb begin
    w_next     = r_state;
    w_memWe    = 1'b0;
    w_memAddr  = '0;
    w_memWdata = '0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            w_next = DONE;
          end else if (i_mode) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end

      READ: begin
        w_memAddr = r_srcPtr;
        if (i_abort) begin
          w_next = DONE;
        end else begin
          w_next = WRITE;
        end
      end

      WRITE: begin
        w_memWe    = 1'b1;
        w_memAddr  = r_dstPtr;
        w_memWdata = r_mode ? r_fillValue : r_dataQ;
        if (i_abort || w_lastEntry) begin
          w_next = DONE;
        end else if (r_mode) begin
          w_next = WRITE;
        end else begin
          w_next = READ;
        end
      end

      DONE: begin
        w_next = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register. Reset drops straight back to IDLE, so the cycle after a
  // sampled reset never drives a write even if a transfer was in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transfer parameters captured at an accepted start. Mode and fill byte
  // are held for the whole transfer so the inputs may change freely after
  // start; a start seen while busy never reaches this block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= 1'b0;
      r_fillValue <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_mode      <= i_mode;
      r_fillValue <= i_fill_value;
    end
  end

  // Address pointers and the remaining-entry count. Pointer arithmetic is
  // plain 32-bit and wraps through zero without any special handling.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_srcPtr <= '0;
      r_dstPtr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_srcPtr <= w_srcAligned;
            r_dstPtr <= w_dstAligned;
            r_count  <= i_len;
          end
        end
        READ: begin
          r_srcPtr <= r_srcPtr + 32'd4;
        end
        WRITE: begin
          r_dstPtr <= r_dstPtr + 32'd4;
          r_count  <= r_count - LEN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Read-data holding register. Copy is a two-cycle read-then-write, so the
  // byte fetched in READ is parked here and replayed as write data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dataQ <= '0;
    end else if (r_state == READ) begin
      r_dataQ <= i_mem_rdata;
    end
  end

  // Completion status. Both the checksum and the abort flag are cleared by
  // an accepted start and otherwise hold their value after done, so software
  // can read them at leisure until the next transfer begins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_checksum <= '0;
      r_aborted  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_checksum <= '0;
            r_aborted  <= 1'b0;
          end
        end
        READ: begin
          if (i_abort) begin
            r_aborted <= 1'b1;
          end
        end
        WRITE: begin
          r_checksum <= r_checksum + w_memWdata;
          if (i_abort) begin
            r_aborted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_aborted   = r_aborted;
  assign o_checksum  = r_checksum;
  assign o_mem_we    = w_memWe;
  assign o_mem_addr  = w_memAddr;
  assign o_mem_wdata = w_memWdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
// ---------------------------------------------------------------------------
// Self-checking bench for mem_copy_engine. The bench owns a 1024-entry byte
// memory wired to the engine's memory port. Each transfer is predicted by a
// plain sequential model (entry-by-entry copy/fill over a snapshot of the
// memory) that also yields the expected checksum, write list, completion
// cycle and abort flag. Directed transfers come from a table with constant
// expectations; multi-cycle corner cases are hand-written sequences; the
// rest are random transfers checked against the model only.
// ---------------------------------------------------------------------------
module tb_mem_copy_engine;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic             abort;
  logic [31:0]      srcAddr;
  logic [31:0]      dstAddr;
  logic [LEN_W-1:0] len;
  logic [7:0]       fillValue;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [7:0]       checksum;
  logic             memWe;
  logic [31:0]      memAddr;
  logic [7:0]       memWdata;
  logic [7:0]       memRdata;

  logic [7:0]  mem    [0:1023];
  logic [7:0]  expMem [0:1023];
  logic [31:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];
  logic [31:0] expAddrQ[$];
  logic [7:0]  expDataQ[$];
  int          doneCount = 0;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    string       name;
    bit          mode;
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic [7:0]  fill;
    int          abortCycle;
    int          pokeCycle;
    logic [7:0]  expSum;
    int          expDone;
    int          expWrites;
    bit          expAborted;
  } vec_t;

  vec_t vecs[7];

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_abort      (abort),
    .i_src_addr   (srcAddr),
    .i_dst_addr   (dstAddr),
    .i_len        (len),
    .i_fill_value (fillValue),
    .o_busy       (busy),
    .o_done       (done),
    .o_aborted    (aborted),
    .o_checksum   (checksum),
    .o_mem_we     (memWe),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .i_mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign memRdata = mem[memAddr[11:2]];

  always @(posedge clk) begin
    if (memWe) begin
      mem[memAddr[11:2]] = memWdata;
    end
  end

  // Monitor: log every write and count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (memWe) begin
      wrAddrQ.push_back(memAddr);
      wrDataQ.push_back(memWdata);
    end
    if (done) begin
      doneCount++;
    end
  end

  function automatic vec_t mkVec(input string name, input bit m,
                                 input logic [31:0] s, input logic [31:0] d,
                                 input int l, input logic [7:0] f,
                                 input int ab, input int poke,
                                 input logic [7:0] es, input int ed,
                                 input int ew, input bit ea);
    vec_t v;
    v.name = name;  v.mode = m;  v.src = s;  v.dst = d;  v.len = l;
    v.fill = f;  v.abortCycle = ab;  v.pokeCycle = poke;
    v.expSum = es;  v.expDone = ed;  v.expWrites = ew;  v.expAborted = ea;
    return v;
  endfunction

  function automatic logic [31:0] wrAddrAt(input int i);
    if (i < wrAddrQ.size()) return wrAddrQ[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: walk the block entry by entry in ascending order over a
  // snapshot of memory, so overlapping copies naturally see earlier writes.
  task automatic modelTransfer(input vec_t v, output logic [7:0] sum,
                               output int doneCyc, output int nWr, output bit ab);
    logic [31:0] s;
    logic [31:0] d;
    logic [7:0]  b;
    int          normal;
    for (int i = 0; i < 1024; i++) expMem[i] = mem[i];
    expAddrQ.delete();
    expDataQ.delete();
    sum = 8'h00;
    ab  = 1'b0;
    if (v.len == 0) begin
      doneCyc = 1;
      nWr     = 0;
    end else begin
      normal = v.mode ? v.len + 1 : 2 * v.len + 1;
      if (v.abortCycle > 0 && v.abortCycle < normal) begin
        ab      = 1'b1;
        doneCyc = v.abortCycle + 1;
        nWr     = v.mode ? v.abortCycle : v.abortCycle / 2;
      end else begin
        doneCyc = normal;
        nWr     = v.len;
      end
    end
    s = v.src & 32'hFFFF_FFFC;
    d = v.dst & 32'hFFFF_FFFC;
    for (int i = 0; i < nWr; i++) begin
      b = v.mode ? v.fill : expMem[s[11:2]];
      expMem[d[11:2]] = b;
      expAddrQ.push_back(d);
      expDataQ.push_back(b);
      sum = sum + b;
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // Start one transfer and follow it until done (bounded), driving abort and
  // an optional stray start pulse at the requested cycles.
  task automatic applyStimulus(input vec_t v, output int doneCycle);
    int cyc;
    @(negedge clk);
    wrAddrQ.delete();
    wrDataQ.delete();
    mode = v.mode;  srcAddr = v.src;  dstAddr = v.dst;
    len = LEN_W'(v.len);  fillValue = v.fill;  abort = 1'b0;  start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    doneCycle = -1;
    while (cyc <= 5000) begin
      if (done) begin
        doneCycle = cyc;
        break;
      end
      abort = (v.abortCycle != 0) && (cyc == v.abortCycle);
      start = (v.pokeCycle != 0) && (cyc == v.pokeCycle);
      if (start) begin
        mode    = ~v.mode;
        len     = LEN_W'(5);
        dstAddr = 32'h0000_0400;
      end
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic runTransfer(input vec_t v, input bit useTable);
    logic [7:0] expSum;
    int         expDone;
    int         expWrites;
    bit         expAb;
    int         doneCycle;
    int         addrErrs;
    int         dataErrs;
    int         memErrs;
    modelTransfer(v, expSum, expDone, expWrites, expAb);
    applyStimulus(v, doneCycle);
    checkOutput({v.name, "/doneCycle"}, doneCycle, expDone);
    checkOutput({v.name, "/checksum"}, checksum, expSum);
    checkOutput({v.name, "/aborted"}, aborted, expAb);
    checkOutput({v.name, "/writes"}, wrAddrQ.size(), expWrites);
    addrErrs = 0;
    dataErrs = 0;
    for (int i = 0; i < expAddrQ.size() && i < wrAddrQ.size(); i++) begin
      if (wrAddrQ[i] !== expAddrQ[i]) addrErrs++;
      if (wrDataQ[i] !== expDataQ[i]) dataErrs++;
    end
    checkOutput({v.name, "/addrErrs"}, addrErrs, 0);
    checkOutput({v.name, "/dataErrs"}, dataErrs, 0);
    memErrs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== expMem[i]) memErrs++;
    end
    checkOutput({v.name, "/memErrs"}, memErrs, 0);
    if (useTable) begin
      checkOutput({v.name, "/tblDone"}, doneCycle, v.expDone);
      checkOutput({v.name, "/tblSum"}, checksum, v.expSum);
      checkOutput({v.name, "/tblWrites"}, wrAddrQ.size(), v.expWrites);
      checkOutput({v.name, "/tblAborted"}, aborted, v.expAborted);
    end
    @(posedge clk); #1;
    checkOutput({v.name, "/idleBusy"}, busy, 1'b0);
    checkOutput({v.name, "/idleDone"}, done, 1'b0);
    checkOutput({v.name, "/sumHeld"}, checksum, expSum);
  endtask

  initial begin
    vec_t v;
    int   base;
    int   normal;
    int   doneCyc[$];
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h11;  mem[1] = 8'h22;  mem[2] = 8'h33;  mem[3] = 8'h44;

    rst = 1'b1;  start = 1'b0;  mode = 1'b0;  abort = 1'b0;
    srcAddr = '0;  dstAddr = '0;  len = '0;  fillValue = '0;

    //                 name       mode src           dst           len   fill   ab poke sum    done  wr   ab
    vecs[0] = mkVec("copy4",    0, 32'h0000_0000, 32'h0000_0100, 4,    8'h00, 0, 0, 8'hAA, 9,    4,    0);
    vecs[1] = mkVec("copy1",    0, 32'h0000_000C, 32'h0000_03F0, 1,    8'h00, 0, 0, 8'h44, 3,    1,    0);
    vecs[2] = mkVec("fill3",    1, 32'h0000_0000, 32'h0000_0203, 3,    8'h5A, 0, 0, 8'h0E, 4,    3,    0);
    vecs[3] = mkVec("zeroCopy", 0, 32'h0000_0010, 32'h0000_0300, 0,    8'h00, 0, 0, 8'h00, 1,    0,    0);
    vecs[4] = mkVec("abortFill",1, 32'h0000_0000, 32'h0000_0300, 10,   8'h07, 3, 0, 8'h15, 4,    3,    1);
    vecs[5] = mkVec("wrapFill", 1, 32'h0000_0000, 32'hFFFF_FFFC, 2,    8'h81, 0, 1, 8'h02, 3,    2,    0);
    vecs[6] = mkVec("fullFill", 1, 32'h0000_0000, 32'h0000_0000, 1024, 8'h01, 0, 0, 8'h00, 1025, 1024, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst/busy", busy, 1'b0);
    checkOutput("rst/done", done, 1'b0);
    checkOutput("rst/aborted", aborted, 1'b0);
    checkOutput("rst/checksum", checksum, 8'h00);
    checkOutput("rst/memWe", memWe, 1'b0);
    checkOutput("rst/memAddr", memAddr, 32'h0);
    checkOutput("rst/memWdata", memWdata, 8'h00);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      runTransfer(vecs[t], 1'b1);
      if (t == 0) begin
        checkOutput("copy4/m100", mem[64], 8'h11);
        checkOutput("copy4/m104", mem[65], 8'h22);
        checkOutput("copy4/m108", mem[66], 8'h33);
        checkOutput("copy4/m10C", mem[67], 8'h44);
      end else if (t == 2) begin
        checkOutput("fill3/addr0", wrAddrAt(0), 32'h0000_0200);
        checkOutput("fill3/addr2", wrAddrAt(2), 32'h0000_0208);
      end else if (t == 5) begin
        checkOutput("wrapFill/addr0", wrAddrAt(0), 32'hFFFF_FFFC);
        checkOutput("wrapFill/addr1", wrAddrAt(1), 32'h0000_0000);
      end
    end

    // Reset in the middle of a copy: raised during the second READ (cycle 3).
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    wrAddrQ.delete();
    wrDataQ.delete();
    mode = 1'b0;  srcAddr = 32'h0000_0040;  dstAddr = 32'h0000_0500;
    len = LEN_W'(4);  start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = doneCount;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRst/busy", busy, 1'b0);
    checkOutput("midRst/memWe", memWe, 1'b0);
    checkOutput("midRst/checksum", checksum, 8'h00);
    checkOutput("midRst/done", done, 1'b0);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("midRst/noDone", doneCount - base, 0);
    checkOutput("midRst/partialWrites", wrAddrQ.size(), 1);
    runTransfer(mkVec("afterRst", 0, 32'h0000_0040, 32'h0000_0500, 4,
                      8'h00, 0, 0, 8'h00, 0, 0, 0), 1'b0);

    // Back-to-back: start held high re-triggers in the IDLE cycle after DONE.
    @(negedge clk);
    mode = 1'b1;  dstAddr = 32'h0000_0600;  len = LEN_W'(2);
    fillValue = 8'h11;  start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      if (done) doneCyc.push_back(c);
      if (c >= 7) start = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("b2b/pulses", doneCyc.size(), 2);
    checkOutput("b2b/first", (doneCyc.size() > 0) ? doneCyc[0] : -1, 3);
    checkOutput("b2b/second", (doneCyc.size() > 1) ? doneCyc[1] : -1, 7);

    // Random transfers against the model.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 20; r++) begin
      v = mkVec($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom,
                $urandom, $urandom_range(0, 40), 8'($urandom), 0, 0,
                8'h00, 0, 0, 0);
      if (v.len > 0) begin
        normal = v.mode ? v.len + 1 : 2 * v.len + 1;
        if ($urandom_range(0, 3) == 0) v.abortCycle = $urandom_range(1, normal - 1);
        if ($urandom_range(0, 3) == 0) v.pokeCycle = 1;
      end
      runTransfer(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
